dmem_bus_master: RTL and testbench
==================================

# dmem_bus_master

Multi-cycle initiator that turns the memory stage's single-cycle 64-bit data access into a sequence of byte-wide handshake transfers on an external data-memory bus. It sits between the pipeline memory stage and a byte-addressed memory responder. It stalls the pipeline while a transfer is in flight, assembles load data little-endian, and reports out-of-range addresses without issuing any bus traffic.

## Interface
Parameters:
- ADDR_LIMIT, 1024, size of the data memory in bytes; a legal access must satisfy addr + 7 < ADDR_LIMIT.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- req_read_i  input  1  memory stage requests a 64-bit load.
- req_write_i  input  1  memory stage requests a 64-bit store.
- req_addr_i  input  64  byte address of the access.
- req_wdata_i  input  64  store data.
- stall_o  output  1  holds the pipeline while the access is in progress.
- done_o  output  1  one-cycle pulse when the access completes.
- rdata_o  output  64  assembled load data.
- dmem_error_o  output  1  address error or illegal request.
- bus_valid_o  output  1  byte transfer request to the responder.
- bus_ready_i  input  1  responder accepts or completes the current byte.
- bus_we_o  output  1  1 = byte write, 0 = byte read.
- bus_addr_o  output  64  byte address of the current transfer.
- bus_wdata_o  output  8  write byte.
- bus_rdata_i  input  8  read byte, valid in the cycle where bus_valid_o & bus_ready_i.

## Operation
- States: IDLE, XFER, DONE.
- Error check is combinational and applies only in IDLE:
  - err = (req_read_i & req_write_i) | ((req_read_i | req_write_i) & (req_addr_i > ADDR_LIMIT-8)).
  - The comparison is 64-bit unsigned.
- IDLE:
  - err: dmem_error_o = 1, stall_o = 0, no bus transaction, stay in IDLE.
  - Exactly one of read/write and no err: latch addr, wdata and the direction; clear the byte index to 0; stall_o = 1; next state XFER.
- XFER:
  - bus_valid_o = 1, bus_addr_o = base + idx (64-bit add), bus_we_o = latched direction.
  - bus_wdata_o = wdata[8*idx+7 : 8*idx], so byte 0 goes to the lowest address.
  - A byte completes when bus_valid_o & bus_ready_i. On a read, the data register byte idx takes bus_rdata_i.
  - idx increments (3-bit) on each completed byte. When byte 7 completes, next state is DONE.
  - bus_addr_o, bus_we_o and bus_wdata_o stay stable while valid & ~ready.
  - stall_o = 1 throughout XFER.
- DONE:
  - done_o = 1 and stall_o = 0 for exactly one cycle; next state IDLE.
  - Request inputs are ignored in DONE, since they still belong to the completed access.
- rdata_o = assembled data register when in DONE and the access was a read; otherwise 64'b0.
- dmem_error_o is 0 outside IDLE.
- Request inputs are sampled only in IDLE; changes during XFER are ignored.

## Timing
- Reset (async, immediate):
  - state = IDLE, idx = 0, data register = 0.
  - bus_valid_o = 0, done_o = 0, rdata_o = 0, bus_we_o = 0, bus_addr_o = 0, bus_wdata_o = 0.
  - stall_o and dmem_error_o follow the combinational IDLE rules.
- Latency with bus_ready_i constantly 1, request first seen in cycle T:
  - stall_o is high in T..T+8.
  - Bytes 0..7 transfer in T+1..T+8.
  - done_o and rdata_o are valid in T+9.
  - Total: 10 cycles.
- Each cycle with bus_valid_o & ~bus_ready_i adds one cycle; no timeout.
- Reset during XFER:
  - The transfer aborts and bus_valid_o drops asynchronously.
  - Bytes already written stay written; partial read data is discarded.
- An error in IDLE costs zero stall cycles; dmem_error_o is valid in the same cycle as the request.
- Back-to-back requests: a new request can be accepted in IDLE in the cycle after DONE.

## Test plan
- Load at 0x018, responder model holds bytes 05 00 00 00 00 00 00 00, ready tied to 1 -> bus addresses 0x018..0x01F in T+1..T+8; rdata_o = 0x5 with done_o in T+9; stall_o low at T+9.
- Store 0x1122334455667788 to 0x100 -> bus_we_o = 1; bytes 88,77,66,55,44,33,22,11 on addresses 0x100..0x107; done_o at T+9; rdata_o = 0.
- Load 0x0B at 0x040 with bus_ready_i low for 2 cycles on every byte -> outputs stay stable while waiting; done_o at T+25; rdata_o = 0xB.
- Address 0x3F9, then 0xFFFFFFFFFFFFFFF8, then read & write both high -> dmem_error_o = 1 the same cycle; bus_valid_o never rises; stall_o = 0. Address 0x3F8 -> accepted without error, bus address 0x3FF on byte 7.
- Assert rst_i during byte 3 of a store -> bus_valid_o drops immediately; only bytes 0..2 were written. A load issued after reset completes normally in 10 cycles.
- Two loads back to back (0x020 then 0x028) -> done_o pulses in T+9 and T+19 with rdata_o = 0x4 and 0xC.

Source files
------------

// File: rtl/dmem_bus_master.sv
// Byte-serial data-memory initiator: splits a 64-bit load/store into eight
// byte handshakes, little-endian, and flags out-of-range requests in IDLE.
module dmem_bus_master #(
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_read_i,
  input  logic        req_write_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [63:0] rdata_o,
  output logic        dmem_error_o,
  output logic        bus_valid_o,
  input  logic        bus_ready_i,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [7:0]  bus_wdata_o,
  input  logic [7:0]  bus_rdata_i
);

  // state | meaning
  // IDLE  | waiting for a request; error check active
  // XFER  | byte transfers 0..7 in flight, pipeline stalled
  // DONE  | one-cycle completion pulse, load data presented
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [63:0] MAX_ADDR = 64'(ADDR_LIMIT) - 64'd8;

  state_t      state;
  logic [2:0]  idx;
  logic [63:0] base_q;
  logic [63:0] wdata_q;
  logic [63:0] data_q;
  logic        we_q;

  logic req_any;
  logic err;
  logic accept;
  logic in_xfer;

  assign req_any = req_read_i | req_write_i;
  assign err     = (req_read_i & req_write_i) | (req_any & (req_addr_i > MAX_ADDR));
  assign accept  = (state == IDLE) & req_any & ~err;
  assign in_xfer = (state == XFER);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      idx     <= 3'd0;
      base_q  <= 64'd0;
      wdata_q <= 64'd0;
      data_q  <= 64'd0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            base_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            we_q    <= req_write_i;
            idx     <= 3'd0;
            data_q  <= 64'd0;
            state   <= XFER;
          end
        end
        XFER: begin
          if (bus_ready_i) begin
            if (!we_q) data_q[{idx, 3'b000} +: 8] <= bus_rdata_i;
            idx <= idx + 3'd1;
            if (idx == 3'd7) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs decode straight from state so reset removes them immediately.
  assign bus_valid_o  = in_xfer;
  assign bus_we_o     = in_xfer & we_q;
  assign bus_addr_o   = in_xfer ? (base_q + {61'd0, idx}) : 64'd0;
  assign bus_wdata_o  = in_xfer ? wdata_q[{idx, 3'b000} +: 8] : 8'd0;
  assign done_o       = (state == DONE);
  assign rdata_o      = ((state == DONE) && !we_q) ? data_q : 64'd0;
  assign stall_o      = in_xfer | accept;
  assign dmem_error_o = (state == IDLE) & err;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Randomized scoreboard bench for dmem_bus_master with a byte-array responder
// and a reference memory that predicts load data and bus transfers.
module tb_dmem_bus_master;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_read_i, req_write_i;
  logic [63:0] req_addr_i, req_wdata_i;
  logic        stall_o, done_o, dmem_error_o;
  logic [63:0] rdata_o;
  logic        bus_valid_o, bus_ready_i, bus_we_o;
  logic [63:0] bus_addr_o;
  logic [7:0]  bus_wdata_o, bus_rdata_i;

  dmem_bus_master #(.ADDR_LIMIT(1024)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_read_i(req_read_i), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
    .dmem_error_o(dmem_error_o),
    .bus_valid_o(bus_valid_o), .bus_ready_i(bus_ready_i), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_err;
    logic [63:0] rdata;
    int          issue_cyc;
    int          lat;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    bit          we;
    logic [7:0]  wdata;
  } xfer_t;

  resp_t       sb_q[$];
  xfer_t       xq[$];
  logic [7:0]  mem[1024];
  logic [7:0]  ref_mem[1024];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          wcnt = 0;
  bit          hold_pending = 0;
  logic [63:0] h_addr;
  logic        h_we;
  logic [7:0]  h_wdata;

  assign bus_rdata_i = mem[bus_addr_o[9:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk_i) cyc++;

  // Responder ready generation: 0 = always ready, 1 = random, 2 = two wait cycles per byte
  always @(posedge clk_i) begin
    #1;
    if (ready_mode == 0) bus_ready_i = 1'b1;
    else if (ready_mode == 1) bus_ready_i = 1'($urandom_range(0, 1));
    else bus_ready_i = (wcnt >= 2);
  end

  // Monitor: bus transfers, stability while waiting, responses
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (bus_valid_o) begin
        if (hold_pending) begin
          chk("hold_addr", bus_addr_o, h_addr);
          chk("hold_we", 64'(bus_we_o), 64'(h_we));
          chk("hold_wdata", 64'(bus_wdata_o), 64'(h_wdata));
        end
        if (bus_ready_i) begin
          if (xq.size() == 0) begin
            chk("unexpected_xfer", bus_addr_o, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            xfer_t x;
            x = xq.pop_front();
            chk("xfer_addr", bus_addr_o, x.addr);
            chk("xfer_we", 64'(bus_we_o), 64'(x.we));
            if (x.we) chk("xfer_wdata", 64'(bus_wdata_o), 64'(x.wdata));
          end
          if (bus_we_o) mem[bus_addr_o[9:0]] = bus_wdata_o;
          wcnt = 0;
          hold_pending = 0;
        end else begin
          wcnt++;
          hold_pending = 1;
          h_addr = bus_addr_o;
          h_we = bus_we_o;
          h_wdata = bus_wdata_o;
        end
      end else begin
        hold_pending = 0;
      end
      if (done_o || dmem_error_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_resp", 64'(done_o), 64'(0));
        end else begin
          resp_t r;
          r = sb_q.pop_front();
          chk("resp_kind", 64'(dmem_error_o), 64'(r.is_err));
          chk("resp_rdata", rdata_o, r.rdata);
          chk("resp_stall", 64'(stall_o), 64'(0));
          if (r.lat >= 0) chk("resp_latency", 64'(cyc - r.issue_cyc), 64'(r.lat));
        end
      end else begin
        chk("rdata_idle_zero", rdata_o, 64'd0);
      end
    end
  end

  task automatic poke(input logic [63:0] addr, input logic [63:0] val);
    logic [63:0] a;
    for (int i = 0; i < 8; i++) begin
      a = addr + 64'(i);
      mem[a[9:0]] = val[8*i +: 8];
      ref_mem[a[9:0]] = val[8*i +: 8];
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 400;
    while ((sb_q.size() != 0 || xq.size() != 0) && budget > 0) begin
      @(posedge clk_i); #1;
      budget--;
    end
    if (budget == 0) begin
      chk("timeout", 64'(sb_q.size() + xq.size()), 64'd0);
      sb_q.delete();
      xq.delete();
    end
  endtask

  // Called at posedge+1; lat < 0 skips the latency check
  task automatic issue(input logic [63:0] addr, input logic [63:0] wd,
                       input bit rd, input bit wr, input int lat);
    bit          e;
    resp_t       r;
    xfer_t       x;
    logic [63:0] a;
    logic [63:0] expd;
    e = (rd && wr) || ((rd || wr) && (addr > 64'd1016));
    expd = 64'd0;
    req_read_i = rd;
    req_write_i = wr;
    req_addr_i = addr;
    req_wdata_i = wd;
    if (rd || wr) begin
      r.is_err = e;
      r.issue_cyc = cyc;
      r.lat = e ? 0 : lat;
      if (!e) begin
        for (int i = 0; i < 8; i++) begin
          a = addr + 64'(i);
          x.addr = a;
          x.we = wr;
          x.wdata = wd[8*i +: 8];
          xq.push_back(x);
          if (wr) ref_mem[a[9:0]] = wd[8*i +: 8];
          else expd[8*i +: 8] = ref_mem[a[9:0]];
        end
      end
      r.rdata = (rd && !e) ? expd : 64'd0;
      sb_q.push_back(r);
    end
    #1;
    chk("req_stall", 64'(stall_o), 64'((rd || wr) && !e));
    chk("req_error", 64'(dmem_error_o), 64'(e));
    @(posedge clk_i); #1;
    req_read_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i = {$urandom, $urandom};
    req_wdata_i = {$urandom, $urandom};
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    int          T;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    rst_i = 1'b1;
    req_read_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i = 64'd0;
    req_wdata_i = 64'd0;
    bus_ready_i = 1'b1;
    #2;
    chk("rst_valid", 64'(bus_valid_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_rdata", rdata_o, 64'd0);
    chk("rst_addr", bus_addr_o, 64'd0);
    chk("rst_we", 64'(bus_we_o), 64'd0);
    chk("rst_wdata", 64'(bus_wdata_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_error", 64'(dmem_error_o), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Directed cases
    ready_mode = 0;
    poke(64'h018, 64'h5);
    issue(64'h018, 64'd0, 1, 0, 9);
    issue(64'h100, 64'h1122334455667788, 0, 1, 9);
    issue(64'h100, 64'd0, 1, 0, 9);
    ready_mode = 2;
    poke(64'h040, 64'hB);
    issue(64'h040, 64'd0, 1, 0, 25);
    ready_mode = 0;
    issue(64'h3F9, 64'd0, 1, 0, 0);
    issue(64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, 1, 0);
    issue(64'h080, 64'd0, 1, 1, 0);
    issue(64'h3F8, 64'd0, 1, 0, 9);

    // Reset in the middle of a store: bytes 0..2 land, the rest never appear
    poke(64'h200, 64'hA0A1A2A3A4A5A6A7);
    T = cyc;
    req_write_i = 1'b1;
    req_addr_i = 64'h200;
    req_wdata_i = 64'h0102030405060708;
    for (int i = 0; i < 3; i++) begin
      a = 64'h200 + 64'(i);
      xq.push_back('{addr: a, we: 1'b1, wdata: req_wdata_i[8*i +: 8]});
      ref_mem[a[9:0]] = req_wdata_i[8*i +: 8];
    end
    @(posedge clk_i); #1;
    req_write_i = 1'b0;
    while (cyc < T + 4) begin
      @(posedge clk_i); #1;
    end
    rst_i = 1'b1;
    #1;
    chk("abort_valid", 64'(bus_valid_o), 64'd0);
    chk("abort_stall", 64'(stall_o), 64'd0);
    chk("abort_addr", bus_addr_o, 64'd0);
    chk("abort_bytes_left", 64'(xq.size()), 64'd0);
    xq.delete();
    sb_q.delete();
    hold_pending = 0;
    wcnt = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    issue(64'h200, 64'd0, 1, 0, 9);

    // Back-to-back loads
    poke(64'h020, 64'h4);
    poke(64'h028, 64'hC);
    issue(64'h020, 64'd0, 1, 0, 9);
    issue(64'h028, 64'd0, 1, 0, 9);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      int          sel;
      int          kind;
      logic [63:0] ra;
      ready_mode = $urandom_range(0, 2);
      sel = $urandom_range(0, 9);
      if (sel < 8) ra = 64'($urandom_range(0, 1016));
      else if (sel == 8) ra = 64'($urandom_range(1017, 1100));
      else ra = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      kind = $urandom_range(0, 9);
      issue(ra, {$urandom, $urandom}, (kind < 4) || (kind == 9), (kind >= 4 && kind < 8) || (kind == 9),
            (ready_mode == 0) ? 9 : ((ready_mode == 2) ? 25 : -1));
    end

    ready_mode = 0;
    @(posedge clk_i); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
